// File: rtl/lsu_ctrl.sv
// lsu_ctrl: load/store unit controller sequencing one memory access per request (IDLE/ISSUE/CAPTURE/RESP).
// Optional misaligned-access trap enabled by defining LSU_MISALIGN_TRAP_EN.
`ifndef RegWidth
`define RegWidth 64
`endif
`ifndef ImmWidth
`define ImmWidth 64
`endif
`ifndef WdtTypeCnt
`define WdtTypeCnt 4
`endif
`ifndef Wdt8
`define Wdt8 4'b0001
`endif
`ifndef Wdt16
`define Wdt16 4'b0010
`endif
`ifndef Wdt32
`define Wdt32 4'b0100
`endif
`ifndef Wdt64
`define Wdt64 4'b1000
`endif

module lsu_ctrl (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [`RegWidth-1:0]   in_addr,
    input  logic [`RegWidth-1:0]   in_wdata,
    input  logic                   in_load,
    input  logic                   in_store,
    input  logic [`WdtTypeCnt-1:0] in_wdt_op,
    input  logic                   in_sext,
    output logic [`RegWidth-1:0]   mem_raddr,
    output logic [`RegWidth-1:0]   mem_waddr,
    output logic [`RegWidth-1:0]   mem_wdata,
    output logic                   mem_ren,
    output logic                   mem_wen,
    output logic [`WdtTypeCnt-1:0] wdt_op,
    input  logic [`ImmWidth-1:0]   mem_rdata,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [`ImmWidth-1:0]   out_rdata,
    output logic                   out_fault
);
    typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, RESP} state_t;
    state_t state, state_nxt;
    logic [`RegWidth-1:0]   req_addr, req_wdata;
    logic [`WdtTypeCnt-1:0] req_wdt;
    logic                   req_sext, req_load, accept, access, trap;
    logic [`ImmWidth-1:0]   ext;

    assign in_ready  = state == IDLE;
    assign accept    = in_valid && in_ready;
    assign access    = in_load || in_store;
    assign mem_raddr = req_addr;
    assign mem_waddr = req_addr;
    assign mem_wdata = req_wdata;
    assign wdt_op    = req_wdt;

`ifdef LSU_MISALIGN_TRAP_EN
    assign trap = access && ((in_wdt_op == `Wdt16 && in_addr[0]) ||
                             (in_wdt_op == `Wdt32 && |in_addr[1:0]) ||
                             (in_wdt_op == `Wdt64 && |in_addr[2:0]));
`else
    assign trap = 1'b0;
`endif

    // Narrow loads keep only their own bytes; sign bit replicated only when requested
    assign ext = (req_wdt == `Wdt8)  ? {{(`ImmWidth-8){req_sext & mem_rdata[7]}}, mem_rdata[7:0]} :
                 (req_wdt == `Wdt16) ? {{(`ImmWidth-16){req_sext & mem_rdata[15]}}, mem_rdata[15:0]} :
                 (req_wdt == `Wdt32) ? {{(`ImmWidth-32){req_sext & mem_rdata[31]}}, mem_rdata[31:0]} :
                 mem_rdata;

    always_comb begin
        state_nxt = state;
        mem_ren   = 1'b0;
        mem_wen   = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE:    state_nxt = !accept ? IDLE : (access && !trap) ? ISSUE : RESP;
            ISSUE: begin
                mem_ren   = req_load;
                mem_wen   = !req_load;
                state_nxt = req_load ? CAPTURE : RESP;
            end
            CAPTURE: state_nxt = RESP;
            default: begin
                out_valid = 1'b1;
                state_nxt = out_ready ? IDLE : RESP;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            req_addr  <= '0;
            req_wdata <= '0;
            req_wdt   <= '0;
            req_sext  <= 1'b0;
            req_load  <= 1'b0;
            out_rdata <= '0;
            out_fault <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                req_addr  <= in_addr;
                req_wdata <= in_wdata;
                req_wdt   <= in_wdt_op;
                req_sext  <= in_sext;
                req_load  <= in_load;
                out_rdata <= '0;
                out_fault <= trap;
            end
            if (state == CAPTURE)
                out_rdata <= ext;
        end
    end
endmodule

// File: tb/tb_lsu_ctrl.sv
// tb_lsu_ctrl: directed and randomized checks of lsu_ctrl against a byte-width reference model.
`ifndef RegWidth
`define RegWidth 64
`endif
`ifndef ImmWidth
`define ImmWidth 64
`endif
`ifndef WdtTypeCnt
`define WdtTypeCnt 4
`endif
`ifndef Wdt8
`define Wdt8 4'b0001
`endif
`ifndef Wdt16
`define Wdt16 4'b0010
`endif
`ifndef Wdt32
`define Wdt32 4'b0100
`endif
`ifndef Wdt64
`define Wdt64 4'b1000
`endif

module tb_lsu_ctrl;
    logic clk = 0, rst_n = 0;
    logic in_valid = 0, in_load = 0, in_store = 0, in_sext = 0, out_ready = 0;
    logic [63:0] in_addr = 0, in_wdata = 0, mem_rdata, mem_val = 0;
    logic [3:0] in_wdt_op = `Wdt8;
    logic in_ready, mem_ren, mem_wen, out_valid, out_fault;
    logic [63:0] mem_raddr, mem_waddr, mem_wdata, out_rdata;
    logic [3:0] wdt_op;
    int n_cmp = 0, n_bad = 0;

    lsu_ctrl dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_addr(in_addr), .in_wdata(in_wdata), .in_load(in_load), .in_store(in_store),
        .in_wdt_op(in_wdt_op), .in_sext(in_sext), .mem_raddr(mem_raddr), .mem_waddr(mem_waddr),
        .mem_wdata(mem_wdata), .mem_ren(mem_ren), .mem_wen(mem_wen), .wdt_op(wdt_op),
        .mem_rdata(mem_rdata), .out_valid(out_valid), .out_ready(out_ready),
        .out_rdata(out_rdata), .out_fault(out_fault)
    );

    always #5 clk = ~clk;

    // Memory returns the loaded word only in the cycle after mem_ren; garbage otherwise
    always @(posedge clk) mem_rdata <= mem_ren ? mem_val : {$urandom, $urandom};

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    function automatic int nbytes(input logic [3:0] w);
        return w == `Wdt8 ? 1 : w == `Wdt16 ? 2 : w == `Wdt32 ? 4 : 8;
    endfunction

    function automatic bit trapped(input bit ld, input bit st, input logic [3:0] w, input logic [63:0] a);
`ifdef LSU_MISALIGN_TRAP_EN
        return (ld || st) && (a % nbytes(w) != 0);
`else
        return 0;
`endif
    endfunction

    function automatic logic [63:0] model_rdata(input bit ld, input bit tr, input logic [3:0] w,
                                                input bit sx, input logic [63:0] rd);
        int bits = 8 * nbytes(w);
        logic [63:0] mask, v;
        if (!ld || tr) return 0;
        if (bits == 64) return rd;
        mask = (64'd1 << bits) - 1;
        v = rd & mask;
        if (sx && v[bits-1]) v = v | ~mask;
        return v;
    endfunction

    task automatic run_req(input bit ld, input bit st, input logic [3:0] w, input logic [63:0] a,
                           input logic [63:0] d, input bit sx, input logic [63:0] rd, input int hold,
                           output int lat, output logic [63:0] rdata, output logic fault,
                           output int ren_n, output int wen_n, output bit ovl, output bit addr_ok,
                           output bit hold_ok, output bit busy_ok);
        int n = 0;
        mem_val = rd; lat = -1; ren_n = 0; wen_n = 0; ovl = 0;
        addr_ok = 1; hold_ok = 1; busy_ok = 1; rdata = 'x; fault = 'x;
        @(negedge clk);
        in_valid = 1; in_load = ld; in_store = st; in_wdt_op = w;
        in_addr = a; in_wdata = d; in_sext = sx; out_ready = (hold == 0);
        while (!in_ready && n < 20) begin @(negedge clk); n++; end
        if (!in_ready) begin in_valid = 0; return; end
        @(posedge clk); #1;
        in_valid = 0; in_load = $urandom; in_store = $urandom; in_sext = $urandom;
        in_wdt_op = 4'($urandom); in_addr = {$urandom, $urandom}; in_wdata = {$urandom, $urandom};
        for (int c = 1; c <= 8 && lat < 0; c++) begin
            @(negedge clk);
            if (in_ready) busy_ok = 0;
            if (mem_ren && mem_wen) ovl = 1;
            if (mem_ren) begin ren_n++; if (mem_raddr !== a || wdt_op !== w) addr_ok = 0; end
            if (mem_wen) begin wen_n++; if (mem_waddr !== a || mem_wdata !== d || wdt_op !== w) addr_ok = 0; end
            if (out_valid) begin lat = c; rdata = out_rdata; fault = out_fault; end
        end
        if (lat < 0) begin out_ready = 1; return; end
        for (int h = 1; h < hold; h++) begin
            @(negedge clk);
            if (!out_valid || out_rdata !== rdata || out_fault !== fault) hold_ok = 0;
            if (in_ready) busy_ok = 0;
            if (mem_ren || mem_wen) ovl = 1;
        end
        out_ready = 1;
        @(negedge clk);
        if (out_valid || !in_ready) hold_ok = 0;
    endtask

    task automatic test_reset();
        rst_n = 0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({in_ready, out_valid, mem_ren, mem_wen, out_fault} !== 5'b10000 || out_rdata !== 0 || mem_raddr !== 0) begin
            n_bad++;
            $display("FAIL reset_state: rdy/vld/ren/wen/flt=%b rdata=%h raddr=%h, want 10000 0 0",
                     {in_ready, out_valid, mem_ren, mem_wen, out_fault}, out_rdata, mem_raddr);
        end
        rst_n = 1;
        @(negedge clk);
        n_cmp++;
        if (in_ready !== 1 || out_valid !== 0) begin
            n_bad++; $display("FAIL reset_release: in_ready=%b out_valid=%b, want 1 0", in_ready, out_valid);
        end
    endtask

    task automatic test_load_sext();
        int lat, rn, wn; logic [63:0] rdata; logic flt; bit ovl, aok, hok, bok;
        run_req(1, 0, `Wdt8, 64'h80000003, 0, 1, 64'h80, 0, lat, rdata, flt, rn, wn, ovl, aok, hok, bok);
        n_cmp++;
        if (lat !== 3) begin n_bad++; $display("FAIL load_sext_latency: got %0d want 3", lat); end
        n_cmp++;
        if (rn !== 1 || wn !== 0 || !aok) begin
            n_bad++; $display("FAIL load_sext_strobe: ren=%0d wen=%0d addr_ok=%0d, want 1 0 1", rn, wn, aok);
        end
        n_cmp++;
        if (rdata !== 64'hFFFFFFFFFFFFFF80) begin
            n_bad++; $display("FAIL load_sext_data: got %h want FFFFFFFFFFFFFF80", rdata);
        end
    endtask

    task automatic test_store();
        int lat, rn, wn; logic [63:0] rdata; logic flt; bit ovl, aok, hok, bok;
        run_req(0, 1, `Wdt32, 64'h80000010, 64'h12345678, 0, 64'hDEAD, 0, lat, rdata, flt, rn, wn, ovl, aok, hok, bok);
        n_cmp++;
        if (lat !== 2) begin n_bad++; $display("FAIL store_latency: got %0d want 2", lat); end
        n_cmp++;
        if (rn !== 0 || wn !== 1 || !aok) begin
            n_bad++; $display("FAIL store_strobe: ren=%0d wen=%0d addr_ok=%0d, want 0 1 1", rn, wn, aok);
        end
        n_cmp++;
        if (rdata !== 0 || flt !== 0) begin n_bad++; $display("FAIL store_data: got %h/%b want 0/0", rdata, flt); end
    endtask

    task automatic test_hold();
        int lat, rn, wn; logic [63:0] rdata; logic flt; bit ovl, aok, hok, bok;
        run_req(1, 0, `Wdt32, 64'h80000040, 0, 0, 64'hDEADBEEF, 5, lat, rdata, flt, rn, wn, ovl, aok, hok, bok);
        n_cmp++;
        if (lat !== 3 || rdata !== 64'h00000000DEADBEEF) begin
            n_bad++; $display("FAIL hold_data: lat=%0d rdata=%h, want 3 00000000DEADBEEF", lat, rdata);
        end
        n_cmp++;
        if (!hok || !bok) begin n_bad++; $display("FAIL hold_stable: hold_ok=%0d busy_ok=%0d, want 1 1", hok, bok); end
    endtask

    task automatic test_noop_and_both();
        int lat, rn, wn; logic [63:0] rdata; logic flt; bit ovl, aok, hok, bok;
        run_req(0, 0, `Wdt64, 64'h80000001, 64'h5, 1, 64'hFFFF, 0, lat, rdata, flt, rn, wn, ovl, aok, hok, bok);
        n_cmp++;
        if (lat !== 1 || rn !== 0 || wn !== 0 || rdata !== 0 || flt !== 0) begin
            n_bad++; $display("FAIL noop: lat=%0d ren=%0d wen=%0d rdata=%h flt=%b, want 1 0 0 0 0", lat, rn, wn, rdata, flt);
        end
        run_req(1, 1, `Wdt16, 64'h80000002, 64'h7, 1, 64'h1234_8001, 0, lat, rdata, flt, rn, wn, ovl, aok, hok, bok);
        n_cmp++;
        if (lat !== 3 || rn !== 1 || wn !== 0 || rdata !== 64'hFFFFFFFFFFFF8001) begin
            n_bad++; $display("FAIL both_as_load: lat=%0d ren=%0d wen=%0d rdata=%h, want 3 1 0 FFFFFFFFFFFF8001", lat, rn, wn, rdata);
        end
    endtask

    task automatic test_misalign();
        int lat, rn, wn; logic [63:0] rdata; logic flt; bit ovl, aok, hok, bok;
        int el, er; logic ef; logic [63:0] ed;
`ifdef LSU_MISALIGN_TRAP_EN
        el = 1; er = 0; ef = 1; ed = 0;
`else
        el = 3; er = 1; ef = 0; ed = 64'h0123456789ABCDEF;
`endif
        run_req(1, 0, `Wdt64, 64'h80000004, 0, 0, 64'h0123456789ABCDEF, 0, lat, rdata, flt, rn, wn, ovl, aok, hok, bok);
        n_cmp++;
        if (lat !== el || rn !== er || wn !== 0 || flt !== ef || rdata !== ed) begin
            n_bad++; $display("FAIL misalign: lat=%0d ren=%0d wen=%0d flt=%b rdata=%h, want %0d %0d 0 %b %h",
                              lat, rn, wn, flt, rdata, el, er, ef, ed);
        end
    endtask

    task automatic test_reset_capture();
        bit saw = 0;
        mem_val = 64'h55; out_ready = 1;
        @(negedge clk);
        in_valid = 1; in_load = 1; in_store = 0; in_wdt_op = `Wdt32; in_addr = 64'h80000020; in_sext = 0;
        @(posedge clk); #1;
        in_valid = 0; in_load = 0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 0; #1;
        n_cmp++;
        if (in_ready !== 1 || out_valid !== 0 || mem_ren !== 0 || mem_raddr !== 0) begin
            n_bad++; $display("FAIL reset_in_capture: rdy=%b vld=%b ren=%b raddr=%h, want 1 0 0 0", in_ready, out_valid, mem_ren, mem_raddr);
        end
        @(negedge clk); rst_n = 1;
        @(posedge clk); #1;
        n_cmp++;
        if (in_ready !== 1 || out_valid !== 0) begin
            n_bad++; $display("FAIL reset_release_idle: rdy=%b vld=%b, want 1 0", in_ready, out_valid);
        end
        repeat (4) begin @(negedge clk); if (out_valid || mem_ren || mem_wen) saw = 1; end
        n_cmp++;
        if (saw !== 0) begin n_bad++; $display("FAIL reset_no_response: activity=%0d want 0", saw); end
    endtask

    task automatic test_back_to_back();
        int acc[$], vat[$]; bit ovl = 0; logic [63:0] rd2 = 'x;
        mem_val = 64'h00000000_0000_00F0; out_ready = 1;
        @(negedge clk);
        in_valid = 1; in_load = 0; in_store = 1; in_wdt_op = `Wdt64; in_addr = 64'h80000100; in_wdata = 64'h99; in_sext = 1;
        for (int c = 0; c < 10; c++) begin
            if (in_ready && in_valid) acc.push_back(c);
            if (out_valid) begin vat.push_back(c); rd2 = out_rdata; end
            if (mem_ren && mem_wen) ovl = 1;
            @(posedge clk); #1;
            if (acc.size() == 1 && in_store) begin
                in_load = 1; in_store = 0; in_wdt_op = `Wdt8; in_addr = 64'h80000105; in_sext = 1;
            end else if (acc.size() == 2) in_valid = 0;
            @(negedge clk);
        end
        in_valid = 0;
        n_cmp++;
        if (acc.size() != 2 || acc[0] != 0 || acc[1] != 3) begin
            n_bad++; $display("FAIL b2b_accept: accepts=%p want '{0,3}", acc);
        end
        n_cmp++;
        if (vat.size() != 2 || vat[0] != 2 || vat[1] != 6 || ovl) begin
            n_bad++; $display("FAIL b2b_resp: valid_cycles=%p overlap=%0d want '{2,6} 0", vat, ovl);
        end
        n_cmp++;
        if (rd2 !== 64'hFFFFFFFFFFFFFFF0) begin n_bad++; $display("FAIL b2b_data: got %h want FFFFFFFFFFFFFFF0", rd2); end
    endtask

    task automatic test_random();
        int lat, rn, wn, el, eren, ewen; logic [63:0] rdata, er, a, d, rd; logic flt; bit ovl, aok, hok, bok, ld, st, sx, tr;
        logic [3:0] w;
        for (int i = 0; i < 60; i++) begin
            ld = $urandom_range(0, 1); st = $urandom_range(0, 1); sx = $urandom_range(0, 1);
            w = 4'd1 << $urandom_range(0, 3);
            a = {32'h8000_0000, $urandom}; d = {$urandom, $urandom}; rd = {$urandom, $urandom};
            rd = rd & ((w == `Wdt64) ? '1 : (64'd1 << (8 * nbytes(w))) - 1);
            tr = trapped(ld, st, w, a);
            el = tr ? 1 : ld ? 3 : st ? 2 : 1;
            eren = (ld && !tr) ? 1 : 0;
            ewen = (st && !ld && !tr) ? 1 : 0;
            er = model_rdata(ld, tr, w, sx, rd);
            run_req(ld, st, w, a, d, sx, rd, $urandom_range(0, 3), lat, rdata, flt, rn, wn, ovl, aok, hok, bok);
            n_cmp++;
            if (lat !== el || rn !== eren || wn !== ewen || ovl || !aok || !hok || !bok) begin
                n_bad++; $display("FAIL rand_ctrl[%0d]: lat=%0d ren=%0d wen=%0d ovl=%0d aok=%0d hok=%0d bok=%0d, want %0d %0d %0d 0 1 1 1",
                                  i, lat, rn, wn, ovl, aok, hok, bok, el, eren, ewen);
            end
            n_cmp++;
            if (rdata !== er || flt !== tr) begin
                n_bad++; $display("FAIL rand_data[%0d]: rdata=%h flt=%b, want %h %b", i, rdata, flt, er, tr);
            end
        end
    endtask

    initial begin
        test_reset();
        test_load_sext();
        test_store();
        test_hold();
        test_noop_and_both();
        test_misalign();
        test_reset_capture();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
